// File: rtl/multdiv_ctrl.sv
// Sequencer for the iterative multiply/divide datapath: start pulse -> LOAD -> RUN (ITERS) -> DONE.
// Latency: result_rdy ITERS+2 cycles after the start pulse, or 2 cycles after it on divide-by-zero.
// No backpressure: a new start always wins and aborts any op in LOAD/RUN; the DONE pulse is never stalled.
module multdiv_ctrl #(
    parameter int WIDTH = 32,
    parameter int ITERS = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             ctrl_mult,
    input  logic             ctrl_div,
    input  logic             divisor_zero,
    output logic             op_w_en,
    output logic             acc_clr,
    output logic             acc_w_en,
    output logic             r_en_acc,
    output logic             r_en_result,
    output logic             is_div,
    output logic [CNT_W-1:0] iter,
    output logic             busy,
    output logic             result_rdy,
    output logic             exception
);

    // Reject parameter sets the iteration counter cannot represent.
    generate
        if (ITERS < 2 || ITERS > (1 << CNT_W) || WIDTH < 1) begin : g_bad_params
            $error("multdiv_ctrl: need WIDTH >= 1 and 2 <= ITERS <= 2**CNT_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] iter_nxt;
    logic             is_div_nxt;
    logic             dz;
    logic             dz_nxt;
    logic             start;

    assign start = ctrl_mult | ctrl_div;

    // State, iteration counter and latched op flags; reset forces every Moore output low.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state  <= IDLE;
            iter   <= '0;
            is_div <= 1'b0;
            dz     <= 1'b0;
        end else begin
            state  <= state_nxt;
            iter   <= iter_nxt;
            is_div <= is_div_nxt;
            dz     <= dz_nxt;
        end
    end

    // Next-state logic; a start in any state (re)enters LOAD, multiply taking priority over divide.
    always_comb begin
        state_nxt  = state;
        iter_nxt   = iter;
        is_div_nxt = is_div;
        dz_nxt     = dz;
        case (state)
            IDLE: iter_nxt = '0;
            LOAD: begin
                iter_nxt  = '0;
                state_nxt = dz ? DONE : RUN;
            end
            RUN: begin
                // Counter holds at the last index so DONE still reports ITERS-1.
                if (iter == LAST_ITER) begin
                    state_nxt = DONE;
                end else begin
                    iter_nxt = iter + CNT_W'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
                iter_nxt  = '0;
            end
            default: begin
                state_nxt = IDLE;
                iter_nxt  = '0;
            end
        endcase
        if (start) begin
            state_nxt  = LOAD;
            iter_nxt   = '0;
            is_div_nxt = ~ctrl_mult;
            dz_nxt     = ctrl_div & ~ctrl_mult & divisor_zero;
        end
    end

    // Moore output decode from state and the latched divide-by-zero flag.
    always_comb begin
        op_w_en     = 1'b0;
        acc_clr     = 1'b0;
        acc_w_en    = 1'b0;
        r_en_acc    = 1'b0;
        r_en_result = 1'b0;
        busy        = 1'b0;
        result_rdy  = 1'b0;
        exception   = 1'b0;
        case (state)
            LOAD: begin
                op_w_en = 1'b1;
                acc_clr = 1'b1;
                busy    = 1'b1;
            end
            RUN: begin
                acc_w_en = 1'b1;
                r_en_acc = 1'b1;
                busy     = 1'b1;
            end
            DONE: begin
                result_rdy  = 1'b1;
                r_en_result = 1'b1;
                exception   = dz;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multdiv_ctrl.sv
module tb_multdiv_ctrl;

    localparam int N0 = 32;
    localparam int N1 = 8;
    localparam int NONE_T = -100000;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    logic ctrl_mult = 1'b0;
    logic ctrl_div = 1'b0;
    logic divisor_zero = 1'b0;

    logic       op_w_en0, acc_clr0, acc_w_en0, r_en_acc0, r_en_result0, is_div0, busy0, result_rdy0, exception0;
    logic [5:0] iter0;
    logic       op_w_en1, acc_clr1, acc_w_en1, r_en_acc1, r_en_result1, is_div1, busy1, result_rdy1, exception1;
    logic [3:0] iter1;

    multdiv_ctrl #(.WIDTH(32), .ITERS(N0), .CNT_W(6)) dut0 (
        .clk(clk), .clr_n(clr_n), .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div),
        .divisor_zero(divisor_zero), .op_w_en(op_w_en0), .acc_clr(acc_clr0),
        .acc_w_en(acc_w_en0), .r_en_acc(r_en_acc0), .r_en_result(r_en_result0),
        .is_div(is_div0), .iter(iter0), .busy(busy0), .result_rdy(result_rdy0),
        .exception(exception0)
    );

    multdiv_ctrl #(.WIDTH(8), .ITERS(N1), .CNT_W(4)) dut1 (
        .clk(clk), .clr_n(clr_n), .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div),
        .divisor_zero(divisor_zero), .op_w_en(op_w_en1), .acc_clr(acc_clr1),
        .acc_w_en(acc_w_en1), .r_en_acc(r_en_acc1), .r_en_result(r_en_result1),
        .is_div(is_div1), .iter(iter1), .busy(busy1), .result_rdy(result_rdy1),
        .exception(exception1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: the most recent start (cycle, op type, div-by-zero) and the one before it.
    int   cur_t = NONE_T;
    logic cur_div = 1'b0;
    logic cur_dz = 1'b0;
    int   prev_t = NONE_T;
    logic prev_div = 1'b0;
    logic prev_dz = 1'b0;

    typedef struct {
        int   cyc;
        logic dv;
        logic ex;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Expected outputs d cycles after the last start, derived from the op timeline.
    function automatic logic [8:0] exp_bits(input int d, input int n, input logic dv,
                                            input logic z, output int it);
        logic load, run, done;
        load = (d == 1);
        run  = !z && d >= 2 && d <= n + 1;
        done = z ? (d == 2) : (d == n + 2);
        it   = run ? d - 2 : ((done && !z) ? n - 1 : 0);
        return {load, load, run, run, done, dv, load | run, done, done & z};
    endfunction

    function automatic exp_t mk_exp(input int c, input logic dv, input logic ex);
        exp_t e;
        e.cyc = c;
        e.dv  = dv;
        e.ex  = ex;
        return e;
    endfunction

    // Record a start issued in the current cycle and queue the result it should produce.
    task automatic issue(input logic m, input logic d, input logic z);
        exp_t e;
        prev_t   = cur_t;
        prev_div = cur_div;
        prev_dz  = cur_dz;
        cur_t    = cyc;
        cur_div  = d & ~m;
        cur_dz   = d & ~m & z;
        if (sb0.size() > 0 && sb0[$].cyc > cyc) void'(sb0.pop_back());
        if (sb1.size() > 0 && sb1[$].cyc > cyc) void'(sb1.pop_back());
        e = mk_exp(cur_dz ? cyc + 2 : cyc + 2 + N0, cur_div, cur_dz);
        sb0.push_back(e);
        e = mk_exp(cur_dz ? cyc + 2 : cyc + 2 + N1, cur_div, cur_dz);
        sb1.push_back(e);
    endtask

    task automatic step(input logic m, input logic d, input logic z);
        @(posedge clk);
        #1;
        ctrl_mult    = m;
        ctrl_div     = d;
        divisor_zero = z;
        if (m | d) issue(m, d, z);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom_range(0, 1) == 1);
    endtask

    task automatic model_reset();
        cur_t = NONE_T; cur_div = 1'b0; cur_dz = 1'b0;
        prev_t = NONE_T; prev_div = 1'b0; prev_dz = 1'b0;
        sb0.delete();
        sb1.delete();
    endtask

    // Monitor: full output comparison every cycle plus scoreboard pop on each result pulse.
    always @(negedge clk) begin
        int   t, it0, it1;
        logic dv, z;
        logic [8:0] e0, e1;
        exp_t got;
        if (!clr_n) begin
            e0 = '0; e1 = '0; it0 = 0; it1 = 0;
        end else begin
            t  = (cur_t == cyc) ? prev_t : cur_t;
            dv = (cur_t == cyc) ? prev_div : cur_div;
            z  = (cur_t == cyc) ? prev_dz : cur_dz;
            e0 = exp_bits(cyc - t, N0, dv, z, it0);
            e1 = exp_bits(cyc - t, N1, dv, z, it1);
        end
        check("outs_n32", {op_w_en0, acc_clr0, acc_w_en0, r_en_acc0, r_en_result0,
                           is_div0, busy0, result_rdy0, exception0}, e0);
        check("iter_n32", iter0, it0);
        check("outs_n8", {op_w_en1, acc_clr1, acc_w_en1, r_en_acc1, r_en_result1,
                          is_div1, busy1, result_rdy1, exception1}, e1);
        check("iter_n8", iter1, it1);
        if (result_rdy0) begin
            if (sb0.size() == 0) begin
                check("sb_n32_unexpected_result", 1, 0);
            end else begin
                got = sb0.pop_front();
                check("sb_n32_cycle", cyc, got.cyc);
                check("sb_n32_isdiv", is_div0, got.dv);
                check("sb_n32_exc", exception0, got.ex);
            end
        end
        if (result_rdy1) begin
            if (sb1.size() == 0) begin
                check("sb_n8_unexpected_result", 1, 0);
            end else begin
                got = sb1.pop_front();
                check("sb_n8_cycle", cyc, got.cyc);
                check("sb_n8_isdiv", is_div1, got.dv);
                check("sb_n8_exc", exception1, got.ex);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic m, d;
        #2;
        check("reset_outs", {op_w_en0, acc_clr0, acc_w_en0, r_en_acc0, r_en_result0,
                             is_div0, busy0, result_rdy0, exception0, iter0}, 0);
        @(posedge clk);
        @(posedge clk);
        #1 clr_n = 1'b1;

        // Reset asserted mid-RUN at iter 12; outputs must drop without a clock edge.
        step(1'b1, 1'b0, 1'b0);
        idle(14);
        #1 check("iter_before_reset", iter0, 12);
        #1 clr_n = 1'b0;
        ctrl_mult = 1'b0; ctrl_div = 1'b0; divisor_zero = 1'b0;
        model_reset();
        #1;
        check("async_reset_n32", {op_w_en0, acc_clr0, acc_w_en0, r_en_acc0, r_en_result0,
                                  is_div0, busy0, result_rdy0, exception0, iter0}, 0);
        check("async_reset_n8", {op_w_en1, acc_clr1, acc_w_en1, r_en_acc1, r_en_result1,
                                 is_div1, busy1, result_rdy1, exception1, iter1}, 0);
        @(posedge clk);
        #1 clr_n = 1'b1;

        // Plain multiply.
        step(1'b1, 1'b0, 1'b1);
        idle(40);
        // Divide by zero.
        step(1'b0, 1'b1, 1'b1);
        idle(10);
        // Divide without zero.
        step(1'b0, 1'b1, 1'b0);
        idle(40);
        // Abort: multiply then divide 12 cycles later.
        step(1'b1, 1'b0, 1'b0);
        idle(11);
        step(1'b0, 1'b1, 1'b0);
        idle(40);
        // Simultaneous starts with divisor_zero high: multiply wins, no exception.
        step(1'b1, 1'b1, 1'b1);
        idle(40);
        // Start in the DONE cycle of the 32-iteration instance.
        step(1'b1, 1'b0, 1'b0);
        idle(33);
        step(1'b0, 1'b1, 1'b0);
        idle(40);
        // Start in the DONE cycle of the 8-iteration instance.
        step(1'b0, 1'b1, 1'b0);
        idle(9);
        step(1'b1, 1'b0, 1'b0);
        idle(12);
        // Start held high for several cycles.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
        idle(40);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 5) begin
                m = $urandom_range(0, 1) == 1;
                d = m ? ($urandom_range(0, 1) == 1) : 1'b1;
                step(m, d, $urandom_range(0, 1) == 1);
            end else begin
                idle(1);
            end
        end
        idle(50);

        check("sb_n32_drained", sb0.size(), 0);
        check("sb_n8_drained", sb1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
